// File: rtl/nco_pkg.sv
// Shared encodings and default widths for the NCO frequency-sweep sequencer.
package nco_pkg;

  localparam int unsigned N_DEF  = 16;
  localparam int unsigned DW_DEF = 16;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_REPEAT = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  // The reserved encoding 2'b11 runs as a single sweep.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_SINGLE : m;
  endfunction

endpackage

// File: rtl/nco_sweep_ctrl_if.sv
// Control and status bundle between a sweep requester and nco_sweep_ctrl.
interface nco_sweep_ctrl_if
  import nco_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned DW = DW_DEF
);

  logic          start;
  logic          abort;
  logic [1:0]    mode;
  logic [N-1:0]  fcw_start;
  logic [N-1:0]  fcw_stop;
  logic [N-1:0]  fcw_step;
  logic [DW-1:0] dwell;
  logic [N-1:0]  fcw;
  logic          busy;
  logic          done;
  logic          step_tick;

  modport master (
    output start, abort, mode, fcw_start, fcw_stop, fcw_step, dwell,
    input  fcw, busy, done, step_tick
  );

  modport slave (
    input  start, abort, mode, fcw_start, fcw_stop, fcw_step, dwell,
    output fcw, busy, done, step_tick
  );

endinterface

// File: rtl/dwell_counter.sv
// Loadable down-counter that times how long each sweep step is held.
module dwell_counter #(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [DW-1:0] i_load_val,
  input  logic          i_dec,
  output logic [DW-1:0] o_count,
  output logic          o_zero_c
);

  logic [DW-1:0] r_count;

  // Load wins over decrement; decrement saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - DW'(1);
    end
  end

  assign o_count  = r_count;
  assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Steps the NCO frequency control word through a start/stop staircase with
// per-step dwell; single, sawtooth-repeat and triangle sweeps.
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  nco_sweep_ctrl_if.slave  bus
);

  logic [0:0]    r_state;
  logic [N-1:0]  r_fcw;
  logic          r_busy;
  logic          r_done;
  logic          r_tick;
  logic [1:0]    r_mode;
  logic [N-1:0]  r_start;
  logic [N-1:0]  r_stop;
  logic [N-1:0]  r_step;
  logic [DW-1:0] r_dmin1;
  logic          r_up;
  logic [N-1:0]  r_target;

  logic [0:0]    w_state_nxt;
  logic [N-1:0]  w_fcw_nxt;
  logic          w_busy_nxt;
  logic          w_done_nxt;
  logic          w_tick_nxt;
  logic [1:0]    w_mode_nxt;
  logic [N-1:0]  w_start_nxt;
  logic [N-1:0]  w_stop_nxt;
  logic [N-1:0]  w_step_nxt;
  logic [DW-1:0] w_dmin1_nxt;
  logic          w_up_nxt;
  logic [N-1:0]  w_target_nxt;
  logic          w_dload;
  logic [DW-1:0] w_dload_val;
  logic          w_ddec;
  logic [DW-1:0] w_dcount;
  logic          w_dzero;
  logic [DW-1:0] w_dmin1_in;

  // One step from cur toward tgt; overshoot, carry, borrow or zero step land on tgt.
  function automatic logic [N-1:0] clamp_step(
    input logic [N-1:0] cur,
    input logic [N-1:0] step,
    input logic [N-1:0] tgt,
    input logic         up
  );
    logic [N:0] sum;
    logic [N:0] diff;
    sum  = {1'b0, cur} + {1'b0, step};
    diff = {1'b0, cur} - {1'b0, step};
    if (step == '0) begin
      return tgt;
    end
    if (up) begin
      return (sum[N] || (sum[N-1:0] >= tgt)) ? tgt : sum[N-1:0];
    end
    return (diff[N] || (diff[N-1:0] <= tgt)) ? tgt : diff[N-1:0];
  endfunction

  assign w_dmin1_in = (bus.dwell == '0) ? '0 : bus.dwell - DW'(1);

  dwell_counter #(.DW(DW)) u_dwell (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_dload),
    .i_load_val (w_dload_val),
    .i_dec      (w_ddec),
    .o_count    (w_dcount),
    .o_zero_c   (w_dzero)
  );

  // Next-state and next-output logic; abort overrides everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_fcw_nxt    = r_fcw;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_tick_nxt   = 1'b0;
    w_mode_nxt   = r_mode;
    w_start_nxt  = r_start;
    w_stop_nxt   = r_stop;
    w_step_nxt   = r_step;
    w_dmin1_nxt  = r_dmin1;
    w_up_nxt     = r_up;
    w_target_nxt = r_target;
    w_dload      = 1'b0;
    w_dload_val  = r_dmin1;
    w_ddec       = 1'b0;

    if (bus.abort) begin
      w_state_nxt = ST_IDLE;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            w_mode_nxt   = norm_mode(bus.mode);
            w_start_nxt  = bus.fcw_start;
            w_stop_nxt   = bus.fcw_stop;
            w_step_nxt   = bus.fcw_step;
            w_dmin1_nxt  = w_dmin1_in;
            w_up_nxt     = (bus.fcw_stop >= bus.fcw_start);
            w_target_nxt = bus.fcw_stop;
            w_fcw_nxt    = bus.fcw_start;
            w_dload      = 1'b1;
            w_dload_val  = w_dmin1_in;
            w_state_nxt  = ST_SWEEP;
            w_busy_nxt   = 1'b1;
            w_tick_nxt   = 1'b1;
          end
        end
        ST_SWEEP: begin
          if (!w_dzero) begin
            w_ddec = 1'b1;
          end else if (r_fcw != r_target) begin
            w_fcw_nxt  = clamp_step(r_fcw, r_step, r_target, r_up);
            w_dload    = 1'b1;
            w_tick_nxt = 1'b1;
          end else begin
            // End of leg.
            case (r_mode)
              MODE_REPEAT: begin
                w_fcw_nxt  = r_start;
                w_dload    = 1'b1;
                w_tick_nxt = 1'b1;
              end
              MODE_TRI: begin
                w_up_nxt     = ~r_up;
                w_target_nxt = (r_target == r_stop) ? r_start : r_stop;
                w_fcw_nxt    = clamp_step(r_fcw, r_step, w_target_nxt, ~r_up);
                w_dload      = 1'b1;
                w_tick_nxt   = 1'b1;
              end
              default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
              end
            endcase
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_fcw    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_tick   <= 1'b0;
      r_mode   <= MODE_SINGLE;
      r_start  <= '0;
      r_stop   <= '0;
      r_step   <= '0;
      r_dmin1  <= '0;
      r_up     <= 1'b1;
      r_target <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_fcw    <= w_fcw_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_tick   <= w_tick_nxt;
      r_mode   <= w_mode_nxt;
      r_start  <= w_start_nxt;
      r_stop   <= w_stop_nxt;
      r_step   <= w_step_nxt;
      r_dmin1  <= w_dmin1_nxt;
      r_up     <= w_up_nxt;
      r_target <= w_target_nxt;
    end
  end

  assign bus.fcw       = r_fcw;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.step_tick = r_tick;

  // Counter value itself is only observed through its zero flag.
  logic w_dcount_unused;
  assign w_dcount_unused = ^w_dcount;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl against a list-of-loads sweep model.
module tb_nco_sweep_ctrl;

  localparam int unsigned N  = 16;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nco_sweep_ctrl_if #(.N(N), .DW(DW)) bus ();
  nco_sweep_ctrl #(.N(N), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int loads[$];
  int exp_fcw = 0;

  // Appends the values visited walking from a to b with clamped steps.
  function automatic void append_leg(longint a, longint b, longint st, bit skip_first);
    longint v;
    v = a;
    if (!skip_first) loads.push_back(int'(v));
    while (v != b) begin
      if (b >= a) v = (st == 0 || v + st >= b) ? b : v + st;
      else        v = (st == 0 || v - st <= b) ? b : v - st;
      loads.push_back(int'(v));
    end
  endfunction

  // Sequence of distinct fcw loads a sweep of this configuration produces.
  function automatic void build_loads(int m, longint s, longint e, longint st, int need);
    bit fwd;
    loads.delete();
    if (m == 1) begin
      while (loads.size() < need) append_leg(s, e, st, 1'b0);
    end else if (m == 2) begin
      if (s == e) begin
        while (loads.size() < need) loads.push_back(int'(s));
      end else begin
        append_leg(s, e, st, 1'b0);
        fwd = 1'b0;
        while (loads.size() < need) begin
          if (fwd) append_leg(s, e, st, 1'b1);
          else     append_leg(e, s, st, 1'b1);
          fwd = ~fwd;
        end
      end
    end else begin
      append_leg(s, e, st, 1'b0);
    end
  endfunction

  // Runs one sweep and checks every cycle; non-single sweeps end with an abort.
  task automatic check_sweep(input int m, input int s, input int e, input int st,
                             input int dw, input int ncyc, input bit noise);
    int d;
    int total;
    bit cont;
    d = (dw == 0) ? 1 : dw;
    cont = (m == 1) || (m == 2);
    build_loads(m, s, e, st, ncyc / d + 2);
    total = cont ? ncyc : loads.size() * d;
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b0; bus.mode = 2'(m);
    bus.fcw_start = 16'(s); bus.fcw_stop = 16'(e); bus.fcw_step = 16'(st);
    bus.dwell = 16'(dw);
    @(posedge clk); #1;
    for (int k = 0; k < total; k++) begin
      checks++;
      if (bus.fcw !== 16'(loads[k / d])) begin
        errors++; $display("FAIL sweep_fcw m=%0d cyc=%0d got=%0d exp=%0d", m, k, bus.fcw, loads[k / d]);
      end
      checks++;
      if (bus.busy !== 1'b1) begin
        errors++; $display("FAIL sweep_busy m=%0d cyc=%0d got=%b exp=1", m, k, bus.busy);
      end
      checks++;
      if (bus.step_tick !== (k % d == 0)) begin
        errors++; $display("FAIL sweep_tick m=%0d cyc=%0d got=%b exp=%b", m, k, bus.step_tick, (k % d == 0));
      end
      checks++;
      if (bus.done !== 1'b0) begin
        errors++; $display("FAIL sweep_done m=%0d cyc=%0d got=%b exp=0", m, k, bus.done);
      end
      if (noise) begin
        bus.start = 1'($urandom_range(0, 1)); bus.mode = 2'($urandom_range(0, 3));
        bus.fcw_start = 16'($urandom); bus.fcw_stop = 16'($urandom);
        bus.fcw_step = 16'($urandom); bus.dwell = 16'($urandom_range(0, 5));
      end else begin
        bus.start = 1'b0;
      end
      if (k < total - 1) begin
        @(posedge clk); #1;
      end
    end
    bus.start = 1'b0;
    bus.abort = cont;
    exp_fcw = cont ? loads[(total - 1) / d] : e;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    checks++;
    if (bus.fcw !== 16'(exp_fcw)) begin
      errors++; $display("FAIL end_fcw m=%0d got=%0d exp=%0d", m, bus.fcw, exp_fcw);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL end_busy m=%0d got=%b exp=0", m, bus.busy);
    end
    checks++;
    if (bus.done !== !cont) begin
      errors++; $display("FAIL end_done m=%0d got=%b exp=%b", m, bus.done, !cont);
    end
    checks++;
    if (bus.step_tick !== 1'b0) begin
      errors++; $display("FAIL end_tick m=%0d got=%b exp=0", m, bus.step_tick);
    end
  endtask

  // Checks one idle cycle: fcw frozen, everything else low.
  task automatic check_idle(input string tag);
    @(posedge clk); #1;
    checks++;
    if (bus.fcw !== 16'(exp_fcw) || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.step_tick !== 1'b0) begin
      errors++;
      $display("FAIL %s got fcw=%0d busy=%b done=%b tick=%b exp fcw=%0d busy=0 done=0 tick=0",
               tag, bus.fcw, bus.busy, bus.done, bus.step_tick, exp_fcw);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (bus.fcw !== 16'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.step_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset got fcw=%0d busy=%b done=%b tick=%b exp all 0", bus.fcw, bus.busy, bus.done, bus.step_tick);
    end
    @(negedge clk); rst_n = 1'b1;
    exp_fcw = 0;
    check_idle("reset_idle");
  endtask

  task automatic test_single_up();
    check_sweep(0, 100, 300, 50, 2, 0, 1'b0);
    check_idle("single_after_done");
  endtask

  task automatic test_clamps();
    check_sweep(0, 0, 200, 70, 1, 0, 1'b0);
    check_sweep(0, 16'hFFF0, 16'hFFFF, 16'h20, 1, 0, 1'b0);
    check_sweep(3, 500, 100, 0, 1, 0, 1'b0);
  endtask

  task automatic test_triangle();
    check_sweep(2, 10, 30, 10, 1, 17, 1'b0);
    check_idle("tri_frozen");
    check_sweep(2, 40, 40, 5, 2, 7, 1'b0);
  endtask

  task automatic test_repeat_down();
    check_sweep(1, 50, 20, 15, 0, 13, 1'b0);
  endtask

  task automatic test_back_to_back();
    check_sweep(0, 1000, 1003, 1, 1, 0, 1'b1);
    check_sweep(0, 7, 3, 2, 3, 0, 1'b1);
    check_sweep(1, 9, 12, 3, 2, 9, 1'b1);
  endtask

  task automatic test_start_abort_idle();
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1; bus.mode = 2'd0;
    bus.fcw_start = 16'd777; bus.fcw_stop = 16'd900; bus.fcw_step = 16'd1; bus.dwell = 16'd1;
    check_idle("start_abort_idle");
    bus.start = 1'b0; bus.abort = 1'b0;
    check_idle("start_abort_idle2");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b0; bus.mode = 2'd2;
    bus.fcw_start = 16'd100; bus.fcw_stop = 16'd5000; bus.fcw_step = 16'd100; bus.dwell = 16'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.fcw !== 16'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.step_tick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got fcw=%0d busy=%b done=%b tick=%b exp all 0", bus.fcw, bus.busy, bus.done, bus.step_tick);
    end
    @(negedge clk); rst_n = 1'b1;
    exp_fcw = 0;
    check_idle("post_reset_idle");
    check_sweep(0, 5, 9, 2, 1, 0, 1'b0);
  endtask

  task automatic test_random();
    int m, s, e, diff, st, dw;
    for (int i = 0; i < 12; i++) begin
      m = int'($urandom_range(0, 3));
      s = int'($urandom_range(0, 65535));
      e = int'($urandom_range(0, 65535));
      diff = (e >= s) ? e - s : s - e;
      st = diff / int'($urandom_range(1, 6)) + int'($urandom_range(0, 2));
      if (st > 65535) st = 65535;
      dw = int'($urandom_range(0, 3));
      check_sweep(m, s, e, st, dw, 30, 1'b1);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 2'd0;
    bus.fcw_start = '0; bus.fcw_stop = '0; bus.fcw_step = '0; bus.dwell = '0;
    test_reset();
    test_single_up();
    test_clamps();
    test_triangle();
    test_repeat_down();
    test_back_to_back();
    test_start_abort_idle();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nco_sweep_ctrl.md
# nco_sweep_ctrl

Frequency-sweep sequencer for the NCO. It drives the NCO's frequency control word (`fcw`) through a programmed staircase from a start word to a stop word. Each step is held for a programmable dwell count. Single-shot, repeating-sawtooth and triangle sweeps are supported. The block sits directly upstream of the `nco` instance, and its `fcw` output connects straight to the NCO `fcw` input on the same `clk`.

## Interface
- `N`, 16, FCW width; must match the NCO `N`
- `DW`, 16, dwell counter width
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low
- `start`  in  1  begin sweep; sampled only in IDLE
- `abort`  in  1  terminate sweep; priority over `start`
- `mode`  in  2  00 single, 01 repeat (sawtooth), 10 triangle; 11 treated as 00
- `fcw_start`  in  N  first FCW of sweep
- `fcw_stop`  in  N  final FCW of leg
- `fcw_step`  in  N  unsigned step magnitude
- `dwell`  in  DW  cycles each FCW is held; 0 treated as 1
- `fcw`  out  N  FCW to NCO, registered
- `busy`  out  1  high while sweeping
- `done`  out  1  one-cycle pulse at single-sweep completion
- `step_tick`  out  1  one-cycle pulse on every edge where `fcw` takes a new sweep value, including the first load

## Operation
- States: IDLE, SWEEP.
- Reset: state IDLE, `fcw`=0, `busy`=0, `done`=0, `step_tick`=0, dwell count 0.
- In IDLE with `start`=1 and `abort`=0, the block latches `mode`, `fcw_start`, `fcw_stop`, `fcw_step` and D=max(`dwell`,1). It then sets `fcw`=`fcw_start`, sets the dwell counter to D-1, sets direction up if `fcw_stop`>=`fcw_start` (unsigned) and down otherwise, sets target=`fcw_stop`, and enters SWEEP. Input changes during SWEEP are ignored.
- `start` while `busy` is ignored.
- In SWEEP, when the dwell counter is nonzero, it decrements.
- In SWEEP, when the dwell counter is 0:
  - `fcw` != target: `fcw` <= clamp(`fcw`±step, target) and the counter reloads D-1.
    - Clamp rule: going up, any sum >= target, or any carry out of N bits, gives target.
    - Going down, any difference <= target, or any borrow, gives target.
    - Step 0 gives target directly.
  - `fcw` == target, end of leg:
    - single: go to IDLE, `done`=1 for one cycle, `fcw` holds target.
    - repeat: `fcw` <= latched start, counter reloads D-1.
    - triangle: direction inverts, target swaps between latched start and stop, then a step is taken toward the new target (clamped).
    - Triangle with start==stop behaves like repeat and holds the value.
- `abort`=1 in any state: next state IDLE, `busy`=0, `fcw` holds its current value, no `done` pulse.
- `step_tick` asserts on every `fcw` load in SWEEP and on the start load. It stays low on abort and on hold cycles.

## Timing
- The `start` sampled at edge t gives `fcw`=`fcw_start`, `busy`=1 and `step_tick`=1 after edge t.
- Each FCW value is held exactly D cycles. A single sweep of K distinct values gives `busy` high for K·D cycles.
- `done` and `busy` falling occur on the same edge.
- New `start` is accepted on the cycle after `done` (back-to-back sweeps, zero gap).
- `fcw` is registered, so the NCO sees each change one cycle after this block's edge.

## Structure
- Shared package `nco_pkg`: mode encodings (`MODE_SINGLE`, `MODE_REPEAT`, `MODE_TRI`), state encoding, default widths N/DW.
- Sub-module `dwell_counter` (load, decrement, zero flag, width DW) is natural. The step/clamp arithmetic stays in the top level.

## Test plan
- Single up: start=100, step=50, stop=300, dwell=2. Expect `fcw` 100,100,150,150,200,200,250,250,300,300, then `done` pulse; `busy` high 10 cycles; 5 `step_tick` pulses.
- Overshoot clamp: start=0, step=70, stop=200, dwell=1. Expect 0,70,140,200 then `done`.
- Carry clamp: start=0xFFF0, step=0x20, stop=0xFFFF, dwell=1. Expect 0xFFF0, 0xFFFF, `done`; no wrap to 0x0010.
- Triangle: start=10, stop=30, step=10, dwell=1. Expect 10,20,30,20,10,20,30… and `done` never pulses. Abort at an arbitrary cycle gives `busy`=0 next edge with `fcw` frozen.
- Repeat down with dwell=0: start=50, stop=20, step=15. Expect 50,35,20,50,35,20… each held 1 cycle.
- Robustness:
  - `start` while busy is ignored.
  - `start`+`abort` in IDLE stays IDLE.
  - `rst_n` low mid-sweep clears all outputs to 0 immediately (asynchronous) and leaves the block in IDLE after release.
